spi_write_router: RTL and testbench

//   Parametrised demux between spi_in and the N LED output engines (icnd2110_out, ws2812_out).

---
 rtl/spi_write_router.sv | 176 +++++++++++++++++
 tb/tb_spi_write_router.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_write_router.sv
// -----------------------------------------------------------------------------
// spi_write_router
//   Routes SPI word writes from spi_in to one of CHANNEL_COUNT LED output
//   engines. The global address space is cut into contiguous per-channel
//   windows whose sizes come from CHANNEL_WORDS. A hit produces a
//   channel-relative address and a one-hot write strobe one cycle later.
//   Each channel also tracks frame progress and flags the last word of a
//   frame. Writes that fall outside every window are counted as errors.
//
// Ports
//   clk                system clock
//   rst                asynchronous reset, active low
//   in_data            word from spi_in
//   in_address         global word address from spi_in (AW1 bits)
//   in_write_strobe    one-cycle write pulse from spi_in
//   clear_errors       synchronous clear of error_count
//   out_data           registered copy of in_data, shared by all channels
//   out_addresses      slice i = in_address - OFFSET[i], registered
//   out_write_strobes  one-hot channel write strobe
//   frame_done         pulse: last word of channel i written
//   frame_complete     qualifies frame_done: whole frame's word count seen
//   error_strobe       pulse: write outside all windows
//   error_count        saturating count of out-of-range writes
// -----------------------------------------------------------------------------
module spi_write_router #(
   parameter int ADDRESS_BUS_WIDTH = 13,
   parameter int DATA_WIDTH        = 16,
   parameter int CHANNEL_COUNT     = 4,
   parameter logic [CHANNEL_COUNT*(ADDRESS_BUS_WIDTH+1)-1:0] CHANNEL_WORDS = {4{14'd0}}
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic [DATA_WIDTH-1:0]                       in_data,
   input  logic [ADDRESS_BUS_WIDTH:0]                  in_address,
   input  logic                                        in_write_strobe,
   input  logic                                        clear_errors,
   output logic [DATA_WIDTH-1:0]                       out_data,
   output logic [CHANNEL_COUNT*(ADDRESS_BUS_WIDTH+1)-1:0] out_addresses,
   output logic [CHANNEL_COUNT-1:0]                    out_write_strobes,
   output logic [CHANNEL_COUNT-1:0]                    frame_done,
   output logic [CHANNEL_COUNT-1:0]                    frame_complete,
   output logic                                        error_strobe,
   output logic [15:0]                                 error_count
);

   localparam int AW1 = ADDRESS_BUS_WIDTH + 1;

   typedef enum logic {
      S_IDLE,
      S_FILLING
   } frame_state_t;

   // Word count of one channel, widened to 32 bits for window arithmetic.
   function automatic int unsigned words_of(input int idx);
      return 32'(CHANNEL_WORDS[idx*AW1 +: AW1]);
   endfunction

   // Base address of a channel: sum of the sizes of all lower channels.
   function automatic int unsigned offset_of(input int idx);
      int unsigned sum;
      sum = 0;
      for (int k = 0; k < idx; k++) begin
         sum = sum + words_of(k);
      end
      return sum;
   endfunction

   localparam int unsigned TOTAL = offset_of(CHANNEL_COUNT);

   // Window compares are done at 32 bits so OFFSET+WORDS cannot wrap.
   logic [31:0] addr_wide;
   assign addr_wide = {{(32-AW1){1'b0}}, in_address};

   logic error_hit;
   assign error_hit = in_write_strobe && (addr_wide >= TOTAL);

   logic [DATA_WIDTH-1:0] data_reg;
   logic                  error_strobe_reg;
   logic [15:0]           error_count_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_reg         <= '0;
         error_strobe_reg <= 1'b0;
         error_count_reg  <= '0;
      end else begin
         data_reg         <= in_data;
         error_strobe_reg <= error_hit;
         // A clear wins over the old count but still counts a coincident error.
         if (clear_errors) begin
            error_count_reg <= error_hit ? 16'd1 : 16'd0;
         end else if (error_hit && (error_count_reg != 16'hFFFF)) begin
            error_count_reg <= error_count_reg + 16'd1;
         end
      end
   end

   assign out_data     = data_reg;
   assign error_strobe = error_strobe_reg;
   assign error_count  = error_count_reg;

   genvar gi;
   generate
      for (gi = 0; gi < CHANNEL_COUNT; gi++) begin : g_chan
         localparam int unsigned      OFF    = offset_of(gi);
         localparam int unsigned      WRD    = words_of(gi);
         localparam logic [AW1-1:0]   OFF_A  = AW1'(OFF);
         // For a disabled channel this wraps, but such a channel never hits.
         localparam logic [AW1-1:0]   LAST_A = AW1'(WRD - 1);
         localparam logic [AW1:0]     WRD_W  = (AW1+1)'(WRD);

         logic           hit;
         logic [AW1-1:0] local_addr;
         logic           is_last;

         frame_state_t   state_reg, state_next;
         logic [AW1-1:0] wcnt_reg, wcnt_next;
         logic           done_next, complete_next;

         logic           strobe_reg, done_reg, complete_reg;
         logic [AW1-1:0] addr_reg;

         assign hit        = in_write_strobe && (WRD != 0) &&
                             (addr_wide >= OFF) && (addr_wide < OFF + WRD);
         assign local_addr = in_address - OFF_A;
         assign is_last    = (local_addr == LAST_A);

         always_comb begin
            state_next    = state_reg;
            wcnt_next     = wcnt_reg;
            done_next     = 1'b0;
            complete_next = 1'b0;
            if (hit) begin
               if (is_last) begin
                  // The final write itself counts toward completeness.
                  done_next     = 1'b1;
                  complete_next = (({1'b0, wcnt_reg} + (AW1+1)'(1)) >= WRD_W);
                  wcnt_next     = '0;
                  state_next    = S_IDLE;
               end else if (state_reg == S_IDLE) begin
                  wcnt_next  = AW1'(1);
                  state_next = S_FILLING;
               end else begin
                  if ({1'b0, wcnt_reg} < WRD_W) begin
                     wcnt_next = wcnt_reg + AW1'(1);
                  end
               end
            end
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               state_reg    <= S_IDLE;
               wcnt_reg     <= '0;
               strobe_reg   <= 1'b0;
               done_reg     <= 1'b0;
               complete_reg <= 1'b0;
               addr_reg     <= '0;
            end else begin
               state_reg    <= state_next;
               wcnt_reg     <= wcnt_next;
               strobe_reg   <= hit;
               done_reg     <= done_next;
               complete_reg <= complete_next;
               addr_reg     <= local_addr;
            end
         end

         assign out_write_strobes[gi]          = strobe_reg;
         assign frame_done[gi]                 = done_reg;
         assign frame_complete[gi]             = complete_reg;
         assign out_addresses[gi*AW1 +: AW1]   = addr_reg;
      end
   endgenerate

endmodule

// File: tb/tb_spi_write_router.sv
// -----------------------------------------------------------------------------
// tb_spi_write_router
//   Directed and randomized bench for spi_write_router using a 4-channel
//   configuration of 2688/2688/1344/672 words (ch0..ch3). Expected values
//   come from a behavioural model built on plain window arithmetic and
//   per-channel integer word counters.
// -----------------------------------------------------------------------------
module tb_spi_write_router;

   localparam int AWB = 13;
   localparam int AW1 = AWB + 1;
   localparam int DW  = 16;
   localparam int NCH = 4;
   localparam logic [NCH*AW1-1:0] CW = {14'd672, 14'd1344, 14'd2688, 14'd2688};

   logic                 clk;
   logic                 rst;
   logic [DW-1:0]        in_data;
   logic [AW1-1:0]       in_address;
   logic                 in_write_strobe;
   logic                 clear_errors;
   logic [DW-1:0]        out_data;
   logic [NCH*AW1-1:0]   out_addresses;
   logic [NCH-1:0]       out_write_strobes;
   logic [NCH-1:0]       frame_done;
   logic [NCH-1:0]       frame_complete;
   logic                 error_strobe;
   logic [15:0]          error_count;

   spi_write_router #(
      .ADDRESS_BUS_WIDTH (AWB),
      .DATA_WIDTH        (DW),
      .CHANNEL_COUNT     (NCH),
      .CHANNEL_WORDS     (CW)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .in_data           (in_data),
      .in_address        (in_address),
      .in_write_strobe   (in_write_strobe),
      .clear_errors      (clear_errors),
      .out_data          (out_data),
      .out_addresses     (out_addresses),
      .out_write_strobes (out_write_strobes),
      .frame_done        (frame_done),
      .frame_complete    (frame_complete),
      .error_strobe      (error_strobe),
      .error_count       (error_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- behavioural reference model ----------------
   int words [NCH] = '{2688, 2688, 1344, 672};
   int offs  [NCH];
   int total;
   int m_cnt [NCH];
   int m_err_count;
   logic [NCH-1:0] exp_strobes, exp_done, exp_complete;
   logic           exp_err;
   logic [DW-1:0]  exp_data;
   int             exp_addr [NCH];

   function automatic logic [AW1-1:0] slice_of(input int c);
      return out_addresses[c*AW1 +: AW1];
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_cnt[c]    = 0;
         exp_addr[c] = 0;
      end
      m_err_count  = 0;
      exp_strobes  = '0;
      exp_done     = '0;
      exp_complete = '0;
      exp_err      = 1'b0;
      exp_data     = '0;
   endtask

   task automatic model_step(input logic stb, input int addr, input logic clr, input logic [DW-1:0] data);
      int hitc;
      int loc;
      exp_data     = data;
      exp_strobes  = '0;
      exp_done     = '0;
      exp_complete = '0;
      exp_err      = 1'b0;
      for (int c = 0; c < NCH; c++) exp_addr[c] = (addr - offs[c]) & ((1 << AW1) - 1);
      if (stb) begin
         hitc = -1;
         for (int c = 0; c < NCH; c++)
            if (words[c] > 0 && addr >= offs[c] && addr < offs[c] + words[c]) hitc = c;
         if (hitc >= 0) begin
            exp_strobes[hitc] = 1'b1;
            loc = addr - offs[hitc];
            if (loc == words[hitc] - 1) begin
               exp_done[hitc]     = 1'b1;
               exp_complete[hitc] = (m_cnt[hitc] + 1 >= words[hitc]);
               m_cnt[hitc]        = 0;
            end else begin
               m_cnt[hitc] = (m_cnt[hitc] + 1 > words[hitc]) ? words[hitc] : m_cnt[hitc] + 1;
            end
         end else begin
            exp_err = 1'b1;
         end
      end
      if (clr) m_err_count = exp_err ? 1 : 0;
      else if (exp_err && m_err_count < 65535) m_err_count++;
   endtask

   // One clock of stimulus: drive at negedge, model, sample at next negedge.
   task automatic cycle(input logic stb, input int addr, input logic clr);
      in_write_strobe = stb;
      in_address      = addr[AW1-1:0];
      in_data         = DW'($urandom);
      clear_errors    = clr;
      model_step(stb, addr, clr, in_data);
      @(posedge clk);
      @(negedge clk);
      in_write_strobe = 1'b0;
      clear_errors    = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b0;
      in_write_strobe = 1'b0; in_address = '0; in_data = '0; clear_errors = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({out_write_strobes, frame_done, frame_complete, error_strobe} !== '0) begin
         errors++; $display("FAIL reset_pulses got %h want 0", {out_write_strobes, frame_done, frame_complete, error_strobe});
      end
      checks++;
      if ({out_data, out_addresses, error_count} !== '0) begin
         errors++; $display("FAIL reset_data got %h want 0", {out_data, out_addresses, error_count});
      end
      rst = 1'b1;
      $display("reset: outputs checked while rst low, released");
   endtask

   task automatic test_routing();
      cycle(1'b1, 0, 1'b0);
      checks++;
      if (out_write_strobes !== 4'b0001 || slice_of(0) !== 14'd0) begin
         errors++; $display("FAIL route_addr0 got stb=%b a0=%0d want stb=0001 a0=0", out_write_strobes, slice_of(0));
      end
      checks++;
      if (out_data !== exp_data) begin
         errors++; $display("FAIL route_data got %h want %h", out_data, exp_data);
      end
      $display("write addr 0 -> strobes %b", out_write_strobes);
      cycle(1'b1, 2688, 1'b0);
      checks++;
      if (out_write_strobes !== 4'b0010 || slice_of(1) !== 14'd0) begin
         errors++; $display("FAIL route_addr2688 got stb=%b a1=%0d want stb=0010 a1=0", out_write_strobes, slice_of(1));
      end
      $display("write addr 2688 -> strobes %b", out_write_strobes);
      // Last word of ch2: window 5376..6719.
      cycle(1'b1, 6719, 1'b0);
      checks++;
      if (out_write_strobes !== 4'b0100 || slice_of(2) !== 14'd1343 ||
          frame_done !== 4'b0100 || frame_complete !== 4'b0000) begin
         errors++; $display("FAIL route_addr6719 got stb=%b a2=%0d done=%b cmp=%b want 0100 1343 0100 0000",
                            out_write_strobes, slice_of(2), frame_done, frame_complete);
      end
      $display("write addr 6719 -> strobes %b", out_write_strobes);
      cycle(1'b1, 7391, 1'b0);
      checks++;
      if (out_write_strobes !== 4'b1000 || slice_of(3) !== 14'd671 || error_strobe !== 1'b0) begin
         errors++; $display("FAIL route_addr7391 got stb=%b a3=%0d err=%b want 1000 671 0",
                            out_write_strobes, slice_of(3), error_strobe);
      end
      $display("write addr 7391 -> strobes %b", out_write_strobes);
      cycle(1'b0, 7391, 1'b0);
      checks++;
      if ({out_write_strobes, frame_done} !== '0) begin
         errors++; $display("FAIL route_idle got stb=%b done=%b want 0", out_write_strobes, frame_done);
      end
   endtask

   task automatic test_errors();
      cycle(1'b1, 7392, 1'b0);
      checks++;
      if (error_strobe !== 1'b1 || out_write_strobes !== 4'b0000 || error_count !== 16'd1) begin
         errors++; $display("FAIL err_total got err=%b stb=%b cnt=%0d want 1 0000 1", error_strobe, out_write_strobes, error_count);
      end
      $display("write addr 7392 -> error_strobe %b count %0d", error_strobe, error_count);
      cycle(1'b1, 7392, 1'b1);
      checks++;
      if (error_count !== 16'd1 || error_strobe !== 1'b1) begin
         errors++; $display("FAIL err_clear_same got cnt=%0d err=%b want 1 1", error_count, error_strobe);
      end
      $display("clear+error -> count %0d", error_count);
      cycle(1'b0, 0, 1'b1);
      checks++;
      if (error_count !== 16'd0 || error_strobe !== 1'b0) begin
         errors++; $display("FAIL err_clear got cnt=%0d err=%b want 0 0", error_count, error_strobe);
      end
      $display("clear -> count %0d", error_count);
   endtask

   task automatic test_frame_full();
      int early;
      early = 0;
      for (int a = 0; a < 2688; a++) begin
         cycle(1'b1, a, 1'b0);
         if (a < 2687 && (frame_done[0] !== 1'b0 || frame_complete[0] !== 1'b0)) early++;
      end
      checks++;
      if (frame_done[0] !== 1'b1 || frame_complete[0] !== 1'b1) begin
         errors++; $display("FAIL frame_full got done=%b cmp=%b want 1 1", frame_done[0], frame_complete[0]);
      end
      checks++;
      if (early != 0) begin
         errors++; $display("FAIL frame_early got %0d early pulses want 0", early);
      end
      $display("ch0 frame 0..2687 -> done %b complete %b", frame_done[0], frame_complete[0]);
   endtask

   task automatic test_frame_partial();
      cycle(1'b1, 5, 1'b0);
      cycle(1'b1, 2687, 1'b0);
      checks++;
      if (frame_done[0] !== 1'b1 || frame_complete[0] !== 1'b0) begin
         errors++; $display("FAIL frame_partial got done=%b cmp=%b want 1 0", frame_done[0], frame_complete[0]);
      end
      $display("ch0 write 5,2687 -> done %b complete %b", frame_done[0], frame_complete[0]);
      for (int a = 0; a < 2688; a++) cycle(1'b1, a, 1'b0);
      checks++;
      if (frame_done[0] !== 1'b1 || frame_complete[0] !== 1'b1) begin
         errors++; $display("FAIL frame_refill got done=%b cmp=%b want 1 1", frame_done[0], frame_complete[0]);
      end
      $display("ch0 full refill -> done %b complete %b", frame_done[0], frame_complete[0]);
   endtask

   task automatic test_reset_midframe();
      int bad;
      int pulses;
      bad = 0;
      pulses = 0;
      for (int a = 0; a < 100; a++) cycle(1'b1, a, 1'b0);
      for (int a = 6720; a < 7391; a++) cycle(1'b1, a, 1'b0);
      cycle(1'b1, 8000, 1'b0);
      // Assert reset mid-cycle with a strobe pending; outputs must clear at once.
      in_write_strobe = 1'b1; in_address = 14'd5;
      #2 rst = 1'b0;
      #1;
      if ({out_write_strobes, frame_done, frame_complete, error_strobe, out_data, out_addresses, error_count} !== '0) bad++;
      repeat (3) begin
         @(negedge clk);
         if ({out_write_strobes, frame_done, frame_complete, error_strobe, out_data, out_addresses, error_count} !== '0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL reset_async got %0d nonzero samples want 0", bad);
      end
      model_reset();
      in_write_strobe = 1'b0;
      rst = 1'b1;
      $display("mid-frame reset applied and released");
      cycle(1'b1, 7391, 1'b0);
      checks++;
      if (out_write_strobes !== 4'b1000 || frame_done !== 4'b1000 || frame_complete !== 4'b0000) begin
         errors++; $display("FAIL reset_discard got stb=%b done=%b cmp=%b want 1000 1000 0000",
                            out_write_strobes, frame_done, frame_complete);
      end
      $display("first write after reset -> strobes %b complete %b", out_write_strobes, frame_complete);
      for (int a = 0; a < 2688; a++) begin
         cycle(1'b1, a, 1'b0);
         if (frame_complete[0] === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 1 || frame_complete[0] !== 1'b1) begin
         errors++; $display("FAIL reset_refill got %0d complete pulses last=%b want 1 1", pulses, frame_complete[0]);
      end
      $display("ch0 frame after reset -> %0d complete pulses", pulses);
   endtask

   task automatic test_saturation();
      cycle(1'b0, 0, 1'b1);
      for (int n = 0; n < 65534; n++) cycle(1'b1, 8000, 1'b0);
      checks++;
      if (error_count !== 16'hFFFE) begin
         errors++; $display("FAIL sat_fffe got %h want fffe", error_count);
      end
      $display("after 65534 errors -> count %h", error_count);
      for (int n = 0; n < 3; n++) begin
         cycle(1'b1, 7392 + n, 1'b0);
         checks++;
         if (error_count !== 16'hFFFF || error_strobe !== 1'b1) begin
            errors++; $display("FAIL sat_hold got cnt=%h err=%b want ffff 1", error_count, error_strobe);
         end
         $display("error write %0d -> count %h", n, error_count);
      end
   endtask

   task automatic test_back_to_back();
      cycle(1'b1, 0, 1'b0);
      checks++;
      if (out_write_strobes !== 4'b0001) begin
         errors++; $display("FAIL b2b_first got %b want 0001", out_write_strobes);
      end
      cycle(1'b1, 2688, 1'b0);
      checks++;
      if (out_write_strobes !== 4'b0010) begin
         errors++; $display("FAIL b2b_second got %b want 0010", out_write_strobes);
      end
      cycle(1'b0, 0, 1'b0);
      checks++;
      if (out_write_strobes !== 4'b0000) begin
         errors++; $display("FAIL b2b_idle got %b want 0000", out_write_strobes);
      end
      $display("back-to-back 0,2688 -> 0001,0010");
   endtask

   task automatic test_random();
      int addr;
      int sel;
      int c;
      int nerr;
      logic stb;
      logic clr;
      nerr = 0;
      for (int n = 0; n < 1000; n++) begin
         sel = $urandom_range(0, 9);
         c   = $urandom_range(0, NCH - 1);
         if (sel <= 3)      addr = $urandom_range(0, 16383);
         else if (sel <= 6) addr = $urandom_range(6720, 7391);
         else if (sel == 7) addr = offs[c] + words[c] - 1;
         else if (sel == 8) addr = $urandom_range(7392, 7400);
         else               addr = offs[c] + $urandom_range(0, 3);
         stb = ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 15) == 0);
         cycle(stb, addr, clr);
         checks++;
         if (out_write_strobes !== exp_strobes || frame_done !== exp_done || frame_complete !== exp_complete ||
             error_strobe !== exp_err || error_count !== 16'(m_err_count) || out_data !== exp_data) begin
            errors++; nerr++;
            $display("FAIL rand_outputs addr=%0d got stb=%b done=%b cmp=%b err=%b cnt=%0d data=%h want %b %b %b %b %0d %h",
                     addr, out_write_strobes, frame_done, frame_complete, error_strobe, error_count, out_data,
                     exp_strobes, exp_done, exp_complete, exp_err, m_err_count, exp_data);
         end
         for (int k = 0; k < NCH; k++) begin
            checks++;
            if (slice_of(k) !== AW1'(exp_addr[k])) begin
               errors++; nerr++;
               $display("FAIL rand_slice%0d addr=%0d got %0d want %0d", k, addr, slice_of(k), exp_addr[k]);
            end
         end
      end
      $display("random: 1000 transactions, %0d mismatching", nerr);
   endtask

   initial begin
      offs[0] = 0;
      for (int c = 1; c < NCH; c++) offs[c] = offs[c-1] + words[c-1];
      total = offs[NCH-1] + words[NCH-1];
      test_reset();
      @(negedge clk);
      test_routing();
      test_errors();
      test_frame_full();
      test_frame_partial();
      test_reset_midframe();
      test_back_to_back();
      test_random();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog timeout");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "timeout");
   end

endmodule
